rem_mod_n: RTL

Serial remainder engine: accepts one binary digit per accepted cycle and maintains the running remainder of the number so far modulo a parametrised divisor DIV. It is the generalised successor of the fixed divide-by-3 detector, adding arbitrary divisor, LSB-first or MSB-first digit order, frame start, input qualification, and a bit counter. It sits between a serial bit source and downstream checksum/divisibility logic.

---
 rtl/rem_mod_n.sv | 114 +++++++++++
 1 files changed

// File: rtl/rem_mod_n.sv
// rem_mod_n: serial remainder engine.
// Consumes one binary digit per qualified cycle and keeps the running remainder
// of the accumulated number modulo DIV. Digits may arrive MSB-first (Horner
// form) or LSB-first (weighted sum with a rolling power-of-two weight).
// Every intermediate sum is below 2*DIV, so reduction is one compare and one
// conditional subtract.
module rem_mod_n #(
  parameter  int DIV   = 3,
  parameter  int LEN_W = 16,
  localparam int RW    = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lsb_first,
  input  logic             x_valid,
  input  logic             x,
  output logic [RW-1:0]    rem_out,
  output logic             div_out,
  output logic             out_valid,
  output logic [LEN_W-1:0] bit_cnt
);

  if (DIV < 2 || DIV > 255) begin : g_bad_div
    $error("rem_mod_n: DIV must be in 2..255");
  end

  localparam logic [RW:0]    DIV_W   = (RW+1)'(DIV);
  localparam logic [RW-1:0]  ONE_R   = RW'(1);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  // Single reduction step: valid because every input is < 2*DIV.
  function automatic logic [RW-1:0] fold(input logic [RW:0] v);
    logic [RW:0] t;
    t = (v >= DIV_W) ? (v - DIV_W) : v;
    return t[RW-1:0];
  endfunction

  logic [RW-1:0]    r_q, w_q;
  logic             mode_q, seen_q, div_q, ov_q;
  logic [LEN_W-1:0] cnt_q;

  logic [RW-1:0]    base_r, base_w;
  logic             base_mode;
  logic [LEN_W-1:0] base_cnt;
  logic [RW:0]      sum_msb, sum_lsb, dbl_w;

  logic [RW-1:0]    r_d, w_d;
  logic             mode_d, seen_d, div_d, ov_d;
  logic [LEN_W-1:0] cnt_d;

  // Frame start clears state first so a digit in the same cycle lands in the new frame.
  always_comb begin
    base_r    = start ? '0 : r_q;
    base_w    = start ? ONE_R : w_q;
    base_mode = start ? lsb_first : mode_q;
    base_cnt  = start ? '0 : cnt_q;
  end

  // Candidate sums, all kept one bit wider than the remainder.
  always_comb begin
    sum_msb = {base_r, 1'b0} + {{RW{1'b0}}, x};
    sum_lsb = {1'b0, base_r} + (x ? {1'b0, base_w} : '0);
    dbl_w   = {base_w, 1'b0};
  end

  // Next-state: hold unless a digit is accepted; start alone only clears.
  always_comb begin
    r_d    = base_r;
    w_d    = base_w;
    mode_d = base_mode;
    seen_d = start ? 1'b0 : seen_q;
    cnt_d  = base_cnt;
    ov_d   = x_valid;
    if (x_valid) begin
      seen_d = 1'b1;
      cnt_d  = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + 1'b1;
      if (base_mode) begin
        r_d = fold(sum_lsb);
        w_d = fold(dbl_w);
      end else begin
        r_d = fold(sum_msb);
      end
    end
    div_d = seen_d & (r_d == '0);
  end

  // State and output registers; reset returns to an empty MSB-first frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= '0;
      w_q    <= ONE_R;
      mode_q <= 1'b0;
      seen_q <= 1'b0;
      div_q  <= 1'b0;
      ov_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      r_q    <= r_d;
      w_q    <= w_d;
      mode_q <= mode_d;
      seen_q <= seen_d;
      div_q  <= div_d;
      ov_q   <= ov_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rem_out   = r_q;
  assign div_out   = div_q;
  assign out_valid = ov_q;
  assign bit_cnt   = cnt_q;

endmodule
